minmax_seq: RTL and testbench
=============================

Name: minmax_seq

Overview:
- Streaming signed min/max reduction engine for 32-bit words.
- Time-shares one existing slt_32 comparator: each accepted word gets a min compare, then a max compare.
- Sits beside the ALU as a small multi-cycle coprocessor, for example for bounds checks.
- Accepts a length-N burst over a valid/ready input and reports min, max, their indices, and a comparator-overflow status.

Parameters:
- CNT_W, 8, width of the length, count and index fields; maximum burst length is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a reduction; sampled only in IDLE.
- len  in  CNT_W  number of words in the burst; sampled with start.
- in_valid  in  1  input word valid.
- in_data  in  32  signed input word.
- in_ready  out  1  engine can accept in_data this cycle.
- busy  out  1  reduction in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- min_out  out  32  smallest signed word.
- max_out  out  32  largest signed word.
- min_idx  out  CNT_W  index of the first occurrence of the minimum.
- max_idx  out  CNT_W  index of the first occurrence of the maximum.
- ovf_seen  out  1  sticky OR of slt_32 overflow over the current burst.
- err_empty  out  1  set when the last start had len==0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: in_ready, busy, done, min_out, max_out, min_idx, max_idx, ovf_seen, err_empty. Internal count and hold register are also 0. Asserting reset mid-burst aborts the burst with no done pulse.
- The FSM has six states: IDLE, FIRST, FETCH, CMP_MIN, CMP_MAX, DONE.
- IDLE: busy=0, in_ready=0.
  - start with len==0: err_empty<=1, done pulses next cycle (through DONE); result registers are left unchanged.
  - start with len!=0: latch len, clear ovf_seen and err_empty, go to FIRST.
- FIRST: busy=1, in_ready=1.
  - On in_valid: min_out=max_out=in_data, min_idx=max_idx=0, cnt=1.
  - Then go to DONE if len==1, else FETCH.
- FETCH: in_ready=1. On in_valid: hold<=in_data, go to CMP_MIN. Without in_valid the FSM stalls with no timeout.
- CMP_MIN: slt_32 rs=hold, rt=min_out. If rd[0]==1: min_out<=hold, min_idx<=cnt. Go to CMP_MAX.
- CMP_MAX: slt_32 rs=max_out, rt=hold. If rd[0]==1: max_out<=hold, max_idx<=cnt.
  - cnt<=cnt+1.
  - If cnt+1==len go to DONE, else FETCH.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0, then IDLE.
- Result registers hold their values until the next accepted non-empty start.
- Only rd[0] of slt_32 is used.
- In CMP states, ovf_seen |= slt_32 overflow.
- Outside CMP states the comparator inputs are driven to 0, and overflow is ignored.
- Ties: comparisons are strictly less-than, so equal values never replace the current result; indices report the first occurrence.
- start while not IDLE is ignored, including in the DONE cycle.
- in_ready is combinational from state only and never depends on in_valid. A word transfers when in_valid && in_ready.
- Throughput: the first word takes 1 cycle after acceptance; each later word takes 3 cycles (FETCH, CMP_MIN, CMP_MAX) with no stalls.
- Latency from start to done with zero stalls is 3*len cycles.
- len is captured at start; changes during a burst have no effect.
- Index/count width is CNT_W. Because len <= 2^CNT_W-1, cnt never wraps.

Decomposition:
- Shared header minmax_defs.vh holds:
  - the 3-bit state encoding localparams (IDLE=0, FIRST=1, FETCH=2, CMP_MIN=3, CMP_MAX=4, DONE=5);
  - the default CNT_W.
- One sub-module: the existing slt_32, instantiated once and shared by both compare states.
- Operand muxing and the FSM stay in minmax_seq.

Test Plan:
- Mixed signs: len=4 with words 0x7fffffff, 0xfffffff9, 0x80000000, 0x00000009, in_valid held high. Required: min_out=0x80000000, min_idx=2, max_out=0x7fffffff, max_idx=0, done on cycle 12 after start.
- Ties: len=3 with words 0x2, 0x2, 0xfffffffa. Required: max_out=0x2, max_idx=0 (first occurrence), min_out=0xfffffffa, min_idx=2.
- Empty and single:
  - len=0: done pulse 1 cycle after start, err_empty=1, results unchanged.
  - len=1 with word 0xffff0003: min=max=0xffff0003, both indices 0, err_empty=0.
- Backpressure: len=3 with words 0xfffffff3, 0xffff0003, 0xc, in_valid low for 5 cycles before each word. Required: in_ready stays high in FETCH, no word is lost, min=0xffff0003 idx1, max=0xc idx2.
- Abort and ignored start: start len=4, pulse start again mid-burst (must be ignored). Then drop rst_n after word 2 is accepted. Required: all outputs go to 0 immediately, no done pulse. A fresh burst after reset completes correctly.
- Overflow status: compare 0x7fffffff against 0x80000000 within one burst. Required: ovf_seen matches the OR of slt_32 overflow over CMP cycles, and is cleared by the next start.

Source files
------------

// File: rtl/minmax_seq_pkg.sv
// minmax_seq shared definitions: FSM state encoding
// and the default width of the length/count/index fields.
package minmax_seq_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRST   = 3'd1,
    S_FETCH   = 3'd2,
    S_CMP_MIN = 3'd3,
    S_CMP_MAX = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/minmax_seq_slt_32.sv
// slt_32: signed 32-bit set-less-than; rd = {31'b0, rs < rt}.
// Ports: rs, rt operands; rd result; ovf = rs - rt overflowed.
module slt_32 (
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] rd,
  output logic        ovf
);

  logic [31:0] w_diff;

  assign w_diff = rs - rt;
  // Overflow only possible when operand signs differ.
  assign ovf = (rs[31] ^ rt[31]) & (w_diff[31] ^ rs[31]);
  assign rd  = {31'd0, w_diff[31] ^ ovf};

endmodule

// File: rtl/minmax_seq.sv
// minmax_seq: streaming signed min/max over a len-word burst.
// Ports: clk, rst_n, start/len, in_valid/in_data/in_ready,
// busy, done, min/max value+index, ovf_seen, err_empty.
module minmax_seq
  import minmax_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      min_out,
  output logic [31:0]      max_out,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] max_idx,
  output logic             ovf_seen,
  output logic             err_empty
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      r_hold;
  logic [31:0]      r_min;
  logic [31:0]      r_max;
  logic [CNT_W-1:0] r_min_idx;
  logic [CNT_W-1:0] r_max_idx;
  logic             r_ovf;
  logic             r_err;
  logic [31:0]      w_rs;
  logic [31:0]      w_rt;
  logic [31:0]      w_unused_rd;
  logic             w_lt;
  logic             w_ovf;

  assign w_cnt_inc = r_cnt + 1'b1;

  // One comparator shared by both compare states.
  always_comb begin
    w_rs = '0;
    w_rt = '0;
    unique case (r_state)
      S_CMP_MIN: begin
        w_rs = r_hold;
        w_rt = r_min;
      end
      S_CMP_MAX: begin
        w_rs = r_max;
        w_rt = r_hold;
      end
      default: ;
    endcase
  end

  slt_32 u_slt (
    .rs  (w_rs),
    .rt  (w_rt),
    .rd  (w_unused_rd),
    .ovf (w_ovf)
  );

  assign w_lt = w_unused_rd[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (len == '0) ? S_DONE : S_FIRST;
      end
      S_FIRST: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid)
          w_next = (r_len == CNT_W'(1)) ? S_DONE
                                        : S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) w_next = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        busy   = 1'b1;
        w_next = S_CMP_MAX;
      end
      S_CMP_MAX: begin
        busy   = 1'b1;
        w_next = (w_cnt_inc == r_len) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_len <= len;
              r_ovf <= 1'b0;
              r_err <= 1'b0;
            end
          end
        end
        S_FIRST: begin
          if (in_valid) begin
            r_min     <= in_data;
            r_max     <= in_data;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_cnt     <= CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (in_valid) r_hold <= in_data;
        end
        S_CMP_MIN: begin
          r_ovf <= r_ovf | w_ovf;
          if (w_lt) begin
            r_min     <= r_hold;
            r_min_idx <= r_cnt;
          end
        end
        S_CMP_MAX: begin
          r_ovf <= r_ovf | w_ovf;
          r_cnt <= w_cnt_inc;
          if (w_lt) begin
            r_max     <= r_hold;
            r_max_idx <= r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign min_out   = r_min;
  assign max_out   = r_max;
  assign min_idx   = r_min_idx;
  assign max_idx   = r_max_idx;
  assign ovf_seen  = r_ovf;
  assign err_empty = r_err;

endmodule

// File: tb/tb_minmax_seq.sv
// tb_minmax_seq: directed self-checking bench for minmax_seq.
// Inputs change 1ns after posedge; outputs are read there too.
module tb_minmax_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] min_out;
  logic [31:0] max_out;
  logic [7:0]  min_idx;
  logic [7:0]  max_idx;
  logic        ovf_seen;
  logic        err_empty;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] vec [4];

  minmax_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .min_out   (min_out),
    .max_out   (max_out),
    .min_idx   (min_idx),
    .max_idx   (max_idx),
    .ovf_seen  (ovf_seen),
    .err_empty (err_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // rel: cycle number of done, start cycle counted as 1.
  task automatic feed(input int n, input int gap,
                      output int rel, output int drops);
    int t0;
    int t;
    drops = 0;
    start = 1'b1;
    len = 8'(n);
    t0 = cyc;
    tick;
    start = 1'b0;
    len = 8'hff;
    for (int i = 0; i < n; i++) begin
      in_data = vec[i];
      in_valid = (gap == 0);
      t = 0;
      while (!in_ready && t < 20) begin
        tick;
        t++;
      end
      n_run++;
      if (!in_ready) begin
        n_fail++;
        $display("FAIL feed_ready word %0d got 0 want 1", i);
      end
      if (gap > 0) begin
        repeat (gap) begin
          if (!in_ready) drops++;
          tick;
        end
        in_valid = 1'b1;
      end
      tick;
    end
    in_valid = 1'b0;
    t = 0;
    while (!done && t < 40) begin
      tick;
      t++;
    end
    rel = done ? (cyc - t0 + 1) : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_run++;
    if ({in_ready, busy, done, ovf_seen, err_empty} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {in_ready, busy, done, ovf_seen, err_empty});
    end
    n_run++;
    if ({min_out, max_out, min_idx, max_idx} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_results got %h want 0",
               {min_out, max_out, min_idx, max_idx});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_mixed;
    int rel;
    int dr;
    vec[0] = 32'h7fffffff;
    vec[1] = 32'hfffffff9;
    vec[2] = 32'h80000000;
    vec[3] = 32'h00000009;
    feed(4, 0, rel, dr);
    n_run++;
    if (rel !== 12) begin
      n_fail++;
      $display("FAIL mixed_latency got %0d want 12", rel);
    end
    n_run++;
    if (min_out !== 32'h80000000 || min_idx !== 8'd2) begin
      n_fail++;
      $display("FAIL mixed_min got %h/%0d want 80000000/2",
               min_out, min_idx);
    end
    n_run++;
    if (max_out !== 32'h7fffffff || max_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL mixed_max got %h/%0d want 7fffffff/0",
               max_out, max_idx);
    end
    // -7 vs 0x7fffffff overflows the subtraction.
    n_run++;
    if (ovf_seen !== 1'b1 || err_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_status got %b%b want 10",
               ovf_seen, err_empty);
    end
    tick;
    n_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_done_pulse got %b%b want 00",
               done, busy);
    end
  endtask

  task automatic test_ties;
    int rel;
    int dr;
    int dc;
    vec[0] = 32'h2;
    vec[1] = 32'h2;
    vec[2] = 32'hfffffffa;
    feed(3, 0, rel, dr);
    n_run++;
    if (max_out !== 32'h2 || max_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL ties_max got %h/%0d want 2/0",
               max_out, max_idx);
    end
    n_run++;
    if (min_out !== 32'hfffffffa || min_idx !== 8'd2) begin
      n_fail++;
      $display("FAIL ties_min got %h/%0d want fffffffa/2",
               min_out, min_idx);
    end
    // Start in the DONE cycle must be ignored.
    dc = done_cnt;
    start = 1'b1;
    len = 8'd0;
    tick;
    start = 1'b0;
    tick;
    tick;
    n_run++;
    if (done_cnt !== dc + 1 || err_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL done_start_ignored got %0d/%b want %0d/0",
               done_cnt, err_empty, dc + 1);
    end
  endtask

  task automatic test_empty_single;
    int rel;
    int dr;
    feed(0, 0, rel, dr);
    n_run++;
    if (rel !== 2) begin
      n_fail++;
      $display("FAIL empty_latency got %0d want 2", rel);
    end
    n_run++;
    if (err_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_err got %b want 1", err_empty);
    end
    n_run++;
    if (min_out !== 32'hfffffffa || max_out !== 32'h2 ||
        min_idx !== 8'd2 || max_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL empty_keep got %h %h %0d %0d want fffffffa 2 2 0",
               min_out, max_out, min_idx, max_idx);
    end
    tick;
    vec[0] = 32'hffff0003;
    feed(1, 0, rel, dr);
    n_run++;
    if (rel !== 3) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 3", rel);
    end
    n_run++;
    if (min_out !== 32'hffff0003 || max_out !== 32'hffff0003 ||
        min_idx !== 8'd0 || max_idx !== 8'd0 ||
        err_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single got %h %h %0d %0d %b want ffff0003 x2 0 0 0",
               min_out, max_out, min_idx, max_idx, err_empty);
    end
    tick;
  endtask

  task automatic test_backpressure;
    int rel;
    int dr;
    vec[0] = 32'hfffffff3;
    vec[1] = 32'hffff0003;
    vec[2] = 32'h0000000c;
    feed(3, 5, rel, dr);
    n_run++;
    if (rel < 0 || dr !== 0) begin
      n_fail++;
      $display("FAIL bp_ready got rel %0d drops %0d want done, 0",
               rel, dr);
    end
    n_run++;
    if (min_out !== 32'hffff0003 || min_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_min got %h/%0d want ffff0003/1",
               min_out, min_idx);
    end
    n_run++;
    if (max_out !== 32'h0000000c || max_idx !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_max got %h/%0d want c/2",
               max_out, max_idx);
    end
    tick;
  endtask

  task automatic test_abort;
    int dc;
    int rel;
    int dr;
    dc = done_cnt;
    start = 1'b1;
    len = 8'd4;
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick;
    in_data = 32'h5;
    start = 1'b1;
    len = 8'd1;
    tick;
    start = 1'b0;
    in_valid = 1'b0;
    n_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_midburst got %b%b want 10",
               busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({in_ready, busy, done, ovf_seen, err_empty} !== 5'b0 ||
        {min_out, max_out, min_idx, max_idx} !== 80'h0) begin
      n_fail++;
      $display("FAIL abort_reset got %b %h want 0",
               {in_ready, busy, done, ovf_seen, err_empty},
               {min_out, max_out, min_idx, max_idx});
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    n_run++;
    if (done_cnt !== dc) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d want %0d", done_cnt, dc);
    end
    vec[0] = 32'h7fffffff;
    vec[1] = 32'hfffffff9;
    vec[2] = 32'h80000000;
    vec[3] = 32'h00000009;
    feed(4, 0, rel, dr);
    n_run++;
    if (rel !== 12 || min_out !== 32'h80000000 ||
        min_idx !== 8'd2 || max_out !== 32'h7fffffff ||
        max_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_fresh got %0d %h %0d %h %0d want 12 80000000 2 7fffffff 0",
               rel, min_out, min_idx, max_out, max_idx);
    end
    tick;
  endtask

  task automatic test_overflow;
    int rel;
    int dr;
    vec[0] = 32'h7fffffff;
    vec[1] = 32'h80000000;
    feed(2, 0, rel, dr);
    n_run++;
    if (ovf_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 1", ovf_seen);
    end
    n_run++;
    if (min_out !== 32'h80000000 || min_idx !== 8'd1 ||
        max_out !== 32'h7fffffff || max_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL ovf_result got %h %0d %h %0d want 80000000 1 7fffffff 0",
               min_out, min_idx, max_out, max_idx);
    end
    tick;
    start = 1'b1;
    len = 8'd2;
    tick;
    start = 1'b0;
    n_run++;
    if (ovf_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear_on_start got %b want 0", ovf_seen);
    end
    in_valid = 1'b1;
    in_data = 32'h1;
    tick;
    in_data = 32'h2;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    n_run++;
    if (done !== 1'b1 || ovf_seen !== 1'b0 ||
        min_out !== 32'h1 || max_out !== 32'h2 ||
        max_idx !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_clean got %b %b %h %h %0d want 1 0 1 2 1",
               done, ovf_seen, min_out, max_out, max_idx);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_mixed;
    test_ties;
    test_empty_single;
    test_backpressure;
    test_abort;
    test_overflow;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
